// File: rtl/mipi_csi2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_csi2_pkg
// Description : Shared capture-controller state encoding and CSI-2 data types.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_csi2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_WAIT_FS = 2'd2,
        ST_FRAME   = 2'd3
    } state_t;

    // Data-type codes also decoded by the deserializer packet parser
    localparam logic [5:0] C_DT_FRAME_START = 6'h00;
    localparam logic [5:0] C_DT_FRAME_END   = 6'h01;
    localparam logic [5:0] C_DT_RAW8        = 6'h2a;
    localparam logic [5:0] C_DT_RAW10       = 6'h2b;

endpackage
`default_nettype wire

// File: rtl/mipi_geom_meter.sv
`default_nettype none
// ============================================================================
// Module      : mipi_geom_meter
// Description : Counts dv pulses per line and lines per frame of a dv/lv/fv
//               stream; latches the geometry of the last completed line/frame.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_geom_meter #(
    parameter int CNT_W = 16
) (
    input  logic             img_clk,
    input  logic             resetb,
    input  logic             dv,
    input  logic             lv,
    input  logic             fv,
    input  logic             clear,
    input  logic             count_en,
    output logic             lv_fall,
    output logic             fv_fall,
    output logic [CNT_W-1:0] pixel_count,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] last_width,
    output logic [CNT_W-1:0] last_height
);

    logic             r_lv_q;
    logic             r_fv_q;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_last_width;
    logic [CNT_W-1:0] r_last_height;

    assign lv_fall     = r_lv_q & ~lv;
    assign fv_fall     = r_fv_q & ~fv;
    assign pixel_count = r_pix_cnt;
    assign line_count  = r_line_cnt;
    assign last_width  = r_last_width;
    assign last_height = r_last_height;

    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            r_lv_q        <= 1'b0;
            r_fv_q        <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_last_width  <= '0;
            r_last_height <= '0;
        end else begin
            // Edge history always tracks so the first fall after enabling is real
            r_lv_q <= lv;
            r_fv_q <= fv;
            if (clear) begin
                r_pix_cnt     <= '0;
                r_line_cnt    <= '0;
                r_last_width  <= '0;
                r_last_height <= '0;
            end else if (count_en) begin
                if (lv_fall) begin
                    r_last_width <= r_pix_cnt;
                    r_pix_cnt    <= '0;
                    r_line_cnt   <= r_line_cnt + CNT_W'(1);
                end else if (lv && dv) begin
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
                // A line ending in the same cycle as the frame still counts
                if (fv_fall) begin
                    r_last_height <= r_line_cnt + CNT_W'(lv_fall);
                    r_line_cnt    <= '0;
                    r_pix_cnt     <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mipi_csi2_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mipi_csi2_capture_ctrl
// Description : Frame-capture sequencer: arms on a clean frame boundary, gates
//               whole frames downstream, counts frames and checks geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_csi2_capture_ctrl
    import mipi_csi2_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TO_W  = 24
) (
    input  logic             img_clk,
    input  logic             resetb,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [CNT_W-1:0] exp_width,
    input  logic [CNT_W-1:0] exp_height,
    input  logic [TO_W-1:0]  timeout_cycles,
    input  logic             des_dv,
    input  logic             des_lv,
    input  logic             des_fv,
    output logic             des_enable,
    output logic             cap_dv,
    output logic             cap_lv,
    output logic             cap_fv,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_height,
    output logic             err_width,
    output logic             err_height,
    output logic             err_timeout
);

    state_t           r_state;
    logic             r_fv_q;
    logic             r_stop_pend;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_cap_dv;
    logic             r_cap_lv;
    logic             r_cap_fv;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_err_width;
    logic             r_err_height;
    logic             r_err_timeout;

    logic             w_fs_rise;
    logic             w_count_en;
    logic             w_clear;
    logic             w_lv_fall;
    logic             w_fv_fall;
    logic [CNT_W-1:0] w_pix_cnt;
    logic [CNT_W-1:0] w_line_cnt;
    logic [CNT_W-1:0] w_lines;
    logic [CNT_W-1:0] w_fc_next;
    logic [TO_W-1:0]  w_to_next;
    logic             w_to_hit;
    logic             w_last_frame;

    assign w_fs_rise    = (r_state == ST_WAIT_FS) && des_fv && !r_fv_q;
    assign w_count_en   = (r_state == ST_FRAME);
    assign w_clear      = (r_state == ST_IDLE) && start && !abort;
    assign w_lines      = w_line_cnt + CNT_W'(w_lv_fall);
    assign w_fc_next    = r_frame_count + CNT_W'(1);
    assign w_to_next    = r_to_cnt + TO_W'(1);
    assign w_to_hit     = (timeout_cycles != '0) && (w_to_next == timeout_cycles);
    assign w_last_frame = stop || r_stop_pend ||
                          ((num_frames != '0) && (w_fc_next == num_frames));

    mipi_geom_meter #(
        .CNT_W (CNT_W)
    ) u_geom (
        .img_clk     (img_clk),
        .resetb      (resetb),
        .dv          (des_dv),
        .lv          (des_lv),
        .fv          (des_fv),
        .clear       (w_clear),
        .count_en    (w_count_en),
        .lv_fall     (w_lv_fall),
        .fv_fall     (w_fv_fall),
        .pixel_count (w_pix_cnt),
        .line_count  (w_line_cnt),
        .last_width  (meas_width),
        .last_height (meas_height)
    );

    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            r_state       <= ST_IDLE;
            r_fv_q        <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_to_cnt      <= '0;
            r_cap_dv      <= 1'b0;
            r_cap_lv      <= 1'b0;
            r_cap_fv      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_width   <= 1'b0;
            r_err_height  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_fv_q       <= des_fv;
            r_frame_done <= 1'b0;
            r_cap_dv     <= 1'b0;
            r_cap_lv     <= 1'b0;
            r_cap_fv     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_clear) begin
                        r_state       <= ST_ARM;
                        r_frame_count <= '0;
                        r_err_width   <= 1'b0;
                        r_err_height  <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_to_cnt      <= '0;
                        r_stop_pend   <= 1'b0;
                    end
                end
                ST_ARM, ST_WAIT_FS: begin
                    if (abort || stop) begin
                        r_state     <= ST_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (w_to_hit) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= w_to_next;
                        if (r_state == ST_ARM) begin
                            if (!des_fv) begin
                                r_state <= ST_WAIT_FS;
                            end
                        end else if (w_fs_rise) begin
                            // The frame-start sample itself is forwarded
                            r_state  <= ST_FRAME;
                            r_to_cnt <= '0;
                            r_cap_dv <= des_dv;
                            r_cap_lv <= des_lv;
                            r_cap_fv <= des_fv;
                        end
                    end
                end
                ST_FRAME: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_cap_dv <= des_dv;
                        r_cap_lv <= des_lv;
                        r_cap_fv <= des_fv;
                        if (stop) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (w_lv_fall && (w_pix_cnt != exp_width)) begin
                            r_err_width <= 1'b1;
                        end
                        if (w_fv_fall) begin
                            if (w_lines != exp_height) begin
                                r_err_height <= 1'b1;
                            end
                            r_frame_done  <= 1'b1;
                            r_frame_count <= w_fc_next;
                            if (w_last_frame) begin
                                r_state     <= ST_IDLE;
                                r_stop_pend <= 1'b0;
                            end else begin
                                r_state <= ST_WAIT_FS;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign des_enable  = (r_state != ST_IDLE);
    assign cap_dv      = r_cap_dv;
    assign cap_lv      = r_cap_lv;
    assign cap_fv      = r_cap_fv;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign err_width   = r_err_width;
    assign err_height  = r_err_height;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/mipi_csi2_capture_ctrl.md
Name: mipi_csi2_capture_ctrl

Overview:
Frame-capture sequencer for the CSI-2 deserializer output (dvo/lvo/fvo stream on img_clk). It owns the deserializer enable and arms capture only on a clean frame boundary. It gates whole frames to the downstream consumer, counts frames, and measures pixels-per-line and lines-per-frame against expected geometry. It sits between the deserializer and the image buffer/DMA, and is configured from host registers already synchronised to img_clk.

Parameters:
CNT_W, 16, width of pixel, line and frame counters
TO_W, 24, width of the no-frame timeout counter

Ports:
img_clk  input  1  deserializer image clock; all logic on its rising edge
resetb  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin capture session
stop  input  1  one-cycle pulse: end session after current frame
abort  input  1  one-cycle pulse: end session immediately
num_frames  input  CNT_W  frames per session; 0 = continuous
exp_width  input  CNT_W  expected dv pulses per line
exp_height  input  CNT_W  expected lines per frame
timeout_cycles  input  TO_W  max cycles waiting for frame start; 0 = disabled
des_dv, des_lv, des_fv  input  1 each  deserializer dvo/lvo/fvo
des_enable  output  1  drives deserializer enable
cap_dv, cap_lv, cap_fv  output  1 each  gated stream to consumer
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse at each captured frame end
frame_count  output  CNT_W  frames completed this session
meas_width, meas_height  output  CNT_W  geometry of last completed line/frame
err_width, err_height, err_timeout  output  1 each  sticky error flags, cleared on start

Behaviour:
- Reset: state IDLE; all outputs 0.
- States: IDLE, ARM, WAIT_FS, FRAME.
- IDLE:
  - start: clear frame_count, errors and counters; go to ARM; des_enable=1 from the next cycle.
  - stop/abort in IDLE: ignored.
- ARM: wait for des_fv==0, so capture never begins mid-frame. Then go to WAIT_FS.
- WAIT_FS: on des_fv rising edge (registered previous-value detect), go to FRAME; that same des_fv sample is forwarded.
- FRAME: cap_* = des_* registered, 1-cycle latency. In all other states cap_* = 0.
- Pixel counter: increments on des_dv while des_lv=1.
  - On des_lv falling: meas_width <= count; err_width set if count != exp_width; line counter +1; pixel counter cleared.
- On des_fv falling in FRAME: meas_height <= line count; err_height set if it != exp_height; line counter cleared; frame_done pulses the next cycle; frame_count +1 (wraps at 2^CNT_W).
  - Then go to IDLE if stop is pending, or if num_frames!=0 and the new frame_count == num_frames. Otherwise go to WAIT_FS.
- stop: latched as pending in ARM/WAIT_FS/FRAME.
  - In ARM/WAIT_FS it takes effect immediately (go to IDLE).
  - Arriving in the same cycle as fv falling: the frame completes normally, then IDLE.
- abort (any non-IDLE state): go to IDLE next cycle. des_enable and cap_* drop that cycle. No frame_done, frame_count unchanged. A partial frame is not counted.
- Timeout:
  - Counter runs in ARM and WAIT_FS and clears on entering FRAME.
  - If timeout_cycles!=0 and counter reaches timeout_cycles: err_timeout=1, go to IDLE.
- des_enable: 1 in ARM/WAIT_FS/FRAME; 0 in IDLE.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- Width checks occur only in FRAME. Lines seen outside FRAME are not counted.
- Asynchronous reset mid-frame: immediate IDLE, all outputs 0, counts lost.

Decomposition:
- Shared package mipi_csi2_pkg:
  - state encoding localparams ST_IDLE/ST_ARM/ST_WAIT_FS/ST_FRAME
  - CSI-2 data-type constants shared with the deserializer (frame start/end, RAW8 0x2a, RAW10 0x2b).
- One sub-module: mipi_geom_meter.
  - Inputs: dv/lv/fv, clear, count_en.
  - Outputs: lv_fall/fv_fall strobes, pixel/line counts, registered last width/height.
  - Reused by the deserializer debug path.
- The FSM, timeout and gating stay in the top module.

Test Plan:
- Two frames of 4 lines x 8 dv, num_frames=2, exp 8x4, start -> des_enable high; two frame_done pulses; frame_count=2; meas_width=8, meas_height=4; no errors; IDLE after second fv fall; busy=0.
- start while des_fv already high mid-frame -> cap_* stay 0 until fv falls then rises; first captured frame complete; frame_count=1 after it.
- Line with 7 dv, exp_width=8 -> err_width=1, meas_width=7, frame still counted. Next start clears err_width.
- timeout_cycles=100, no fv activity -> err_timeout=1 at cycle 100 after start; des_enable=0; busy=0; frame_count=0.
- num_frames=0; stop mid-frame 3 -> frame 3 completes; frame_count=3; IDLE. Abort mid-frame -> cap_* and des_enable 0 next cycle; no frame_done.
- resetb asserted mid-frame -> all outputs 0 immediately. After release, start re-arms from ARM.
